// File: rtl/systolic_input_feeder_if.sv
// Handshake and skewed-activation bus between an upstream vector source,
// the systolic input feeder and the array's left edge.
interface systolic_input_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_data;
    logic                       in_last;
    logic [ROWS*DATA_WIDTH-1:0] act_out;
    logic                       act_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, act_out, act_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, act_out, act_valid, busy, done
    );
endinterface

// File: rtl/systolic_input_feeder.sv
// Skews incoming activation vectors (row r delayed by r advances) onto the
// left edge of a systolic array, then drains zeros until the wavefront exits.
module systolic_input_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input logic                    clk,
    input logic                    reset,
    systolic_input_feeder_if.slave bus
);
    localparam int DRAIN_LEN = ROWS + COLS - 2;
    localparam int CW        = $clog2(DRAIN_LEN + 2);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       valid_q;
    logic                       ready;
    logic                       xfer;
    logic                       adv;
    logic [ROWS*DATA_WIDTH-1:0] src;

    assign ready         = (state_q != DRAIN);
    assign xfer          = bus.in_valid && ready;
    assign adv           = xfer || (state_q == DRAIN);
    assign src           = (state_q == DRAIN) ? '0 : bus.in_data;
    assign bus.in_ready  = ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.act_valid = valid_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= adv;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, STREAM: begin
                if (xfer) begin
                    if (!bus.in_last) begin
                        state_d = STREAM;
                    end else if (DRAIN_LEN == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CW'(DRAIN_LEN);
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row r sees r delay registers before its output stage.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] elem;
        logic [DATA_WIDTH-1:0] out_q;

        assign elem = src[r*DATA_WIDTH +: DATA_WIDTH];
        assign bus.act_out[r*DATA_WIDTH +: DATA_WIDTH] = out_q;

        if (r == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                end else if (adv) begin
                    out_q <= elem;
                end
            end
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dl_q [r];

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                    for (int i = 0; i < r; i++) begin
                        dl_q[i] <= '0;
                    end
                end else if (adv) begin
                    dl_q[0] <= elem;
                    for (int i = 1; i < r; i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                    out_q <= dl_q[r-1];
                end
            end
        end
    end
endmodule
